// File: rtl/vram_pkg.sv
// Shared helpers for the VRAM arbiter: byte-lane count and channel-index width.
package vram_pkg;

  function automatic int lane_cnt(input int dw);
    return dw / 8;
  endfunction

  // Index width never collapses to zero, even for a single channel.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(2);

endpackage

// File: rtl/vram_arb_rr.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves past the winner.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Walk channels starting at the pointer; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    for (int i = 0; i < NCH; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NCH) c = c - NCH;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (vld_o) ptr_d = (idx_o == IW'(NCH - 1)) ? '0 : idx_o + IW'(1);
  end

endmodule

// File: rtl/vram_arb.sv
// Byte-enabled VRAM with NCH round-robin read channels, 1-cycle read latency.
// Define VRAM_ARB_BYPASS_EN to forward same-cycle write data to a colliding read.
module vram_arb
  import vram_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int NCH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     waddr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic [DWIDTH/8-1:0]   wbe,
  input  logic [NCH-1:0]        rreq,
  input  logic [NCH*AWIDTH-1:0] raddr,
  output logic [NCH-1:0]        rack,
  output logic [NCH-1:0]        rvalid,
  output logic [NCH*DWIDTH-1:0] rdata
);

  localparam int NL = lane_cnt(DWIDTH);
  localparam int IW = ch_idx_w(NCH);

  logic [DWIDTH-1:0]     mem_q [0:(1<<AWIDTH)-1];
  logic [IW-1:0]         gidx;
  logic                  gvld;
  logic [AWIDTH-1:0]     ra;
  logic [DWIDTH-1:0]     rd_word;
  logic [NCH-1:0]        rvalid_q;
  logic [NCH*DWIDTH-1:0] rdata_q;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr (
    .clk_i (clk),
    .rst_i (reset),
    .req_i (rreq),
    .gnt_o (rack),
    .idx_o (gidx),
    .vld_o (gvld)
  );

  always_comb ra = raddr[int'(gidx)*AWIDTH +: AWIDTH];

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NL; b++) begin
        if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[ra];
`ifdef VRAM_ARB_BYPASS_EN
    if (we && (waddr == ra)) begin
      for (int b = 0; b < NL; b++) begin
        if (wbe[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
`endif
  end

  // Read stage: only the granted channel's slice is loaded; others hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rack;
      if (gvld) rdata_q[int'(gidx)*DWIDTH +: DWIDTH] <= rd_word;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb with three read channels.
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [2:0]  rreq;
  logic [23:0] raddr;
  logic [2:0]  rack;
  logic [2:0]  rvalid;
  logic [47:0] rdata;

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vcnt[3] = '{0, 0, 0};
  logic [15:0] rrd[3] = '{16'hA000, 16'hB001, 16'hC002};

  vram_arb #(.DWIDTH(16), .AWIDTH(8), .NCH(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wbe    (wbe),
    .rreq   (rreq),
    .raddr  (raddr),
    .rack   (rack),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic cyc(input logic w, input logic [7:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input logic [2:0] rq,
                     input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                     input logic [2:0] erack, input logic [15:0] ed, input string nm);
    exp_t e;
    we = w; waddr = wa; wdata = wd; wbe = be; rreq = rq; raddr = {a2, a1, a0};
    #1;
    chk({nm, "_rack"}, 64'(rack), 64'(erack));
    if (erack != 3'b000 && !reset) begin
      e.ch   = erack[0] ? 0 : (erack[1] ? 1 : 2);
      e.data = ed;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: every rvalid must match the head of the scoreboard, and vice versa.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (rvalid !== 3'b000) begin
      for (int k = 0; k < 3; k++) begin
        if (rvalid[k]) begin
          if (sb.size() == 0) begin
            chk("unexpected_rvalid", 64'(rvalid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rvalid_ch", 64'(k), 64'(e.ch));
            chk("rdata", 64'(rdata[16*k +: 16]), 64'(e.data));
            vcnt[k]++;
          end
        end
      end
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("missing_rvalid", 64'(rvalid), 64'(3'b001 << e.ch));
    end
  end

  initial begin
    logic [15:0] bp_a, bp_b;
    logic [2:0]  g;
`ifdef VRAM_ARB_BYPASS_EN
    bp_a = 16'h5555;
    bp_b = 16'h55CC;
`else
    bp_a = 16'h1111;
    bp_b = 16'h5555;
`endif
    reset = 1'b1; we = 0; waddr = 0; wdata = 0; wbe = 0; rreq = 0; raddr = 0;
    repeat (2) @(negedge clk);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;

    cyc(1, 8'h10, 16'hBEEF, 2'b11, 3'b000, 0, 0, 0, 3'b000, 16'h0, "wr_beef");
    cyc(0, 0, 0, 2'b00, 3'b001, 8'h10, 0, 0, 3'b001, 16'hBEEF, "rd_beef");
    cyc(1, 8'h10, 16'h12AB, 2'b10, 3'b000, 0, 0, 0, 3'b000, 16'h0, "wr_hi");
    cyc(0, 0, 0, 2'b00, 3'b001, 8'h10, 0, 0, 3'b001, 16'h12EF, "rd_12ef");
    cyc(1, 8'h10, 16'hFFFF, 2'b00, 3'b001, 8'h10, 0, 0, 3'b001, 16'h12EF, "wbe0_rd");
    cyc(1, 8'h20, 16'h1111, 2'b11, 3'b000, 0, 0, 0, 3'b000, 16'h0, "wr_1111");
    cyc(1, 8'h20, 16'h5555, 2'b11, 3'b001, 8'h20, 0, 0, 3'b001, bp_a, "rdw_full");
    cyc(0, 0, 0, 2'b00, 3'b001, 8'h20, 0, 0, 3'b001, 16'h5555, "rd_5555");
    cyc(1, 8'h20, 16'hAACC, 2'b01, 3'b001, 8'h20, 0, 0, 3'b001, bp_b, "rdw_lane");
    cyc(0, 0, 0, 2'b00, 3'b001, 8'h20, 0, 0, 3'b001, 16'h55CC, "rd_55cc");

    for (int i = 1; i <= 4; i++)
      cyc(1, 8'(i), {8'(i), 8'(i)}, 2'b11, 3'b000, 0, 0, 0, 3'b000, 16'h0, "wr_seq");
    for (int i = 0; i < 3; i++)
      cyc(1, 8'(8'h30 + i), rrd[i], 2'b11, 3'b000, 0, 0, 0, 3'b000, 16'h0, "wr_rr");

    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 0, 2'b00, 3'b010, 0, 8'(i), 0, 3'b010, {8'(i), 8'(i)}, "ch1_stream");

    cyc(0, 0, 0, 2'b00, 3'b010, 0, 8'h01, 0, 3'b010, 16'h0101, "pre_reset");
    reset = 1'b1;
    cyc(0, 0, 0, 2'b00, 3'b111, 8'h30, 8'h31, 8'h32, 3'b001, 16'h0, "in_reset");
    chk("reset2_rvalid", 64'(rvalid), 64'd0);
    chk("reset2_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      g = 3'(3'b001 << (i % 3));
      cyc(0, 0, 0, 2'b00, 3'b111, 8'h30, 8'h31, 8'h32, g, rrd[i % 3], "rr_all");
    end

    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 3'b000, 16'h0, "idle");
    chk("hold_ch0", 64'(rdata[15:0]), 64'hA000);
    chk("hold_ch1", 64'(rdata[31:16]), 64'hB001);
    chk("hold_ch2", 64'(rdata[47:32]), 64'hC002);
    chk("pulses_ch0", 64'(vcnt[0]), 64'd10);
    chk("pulses_ch1", 64'(vcnt[1]), 64'd8);
    chk("pulses_ch2", 64'(vcnt[2]), 64'd3);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter AWIDTH, default 8, address width; depth is 2**AWIDTH words.
REQ-003 SHALL have parameter NCH, default 2, number of read channels (1..8).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port we, input, 1, write strobe.
REQ-007 SHALL have port waddr, input, AWIDTH, write address.
REQ-008 SHALL have port wdata, input, DWIDTH, write data.
REQ-009 SHALL have port wbe, input, DWIDTH/8, byte-lane enables; bit i gates wdata[8i+7:8i].
REQ-010 SHALL have port rreq, input, NCH, per-channel read request.
REQ-011 SHALL have port raddr, input, NCH*AWIDTH, per-channel read address; channel k uses slice k.
REQ-012 SHALL have port rack, output, NCH, one-hot grant, combinational in the request cycle.
REQ-013 SHALL have port rvalid, output, NCH, per-channel read-data-valid pulse.
REQ-014 SHALL have port rdata, output, NCH*DWIDTH, per-channel read data register.

Function
REQ-015 Write SHALL occur at the rising clk edge when we=1; only lanes with wbe=1 change; we=1 with wbe=0 leaves memory unchanged.
REQ-016 Exactly one read SHALL be granted per cycle when any rreq is high; rack SHALL be all-zero when rreq is all-zero.
REQ-017 Arbitration SHALL be round-robin: search starts at the channel after the last granted one, wrapping NCH-1 to 0.
REQ-018 A requester SHALL hold rreq and raddr stable until it sees rack; the block SHALL drop nothing that it has acknowledged.
REQ-019 Read latency SHALL be 1 cycle: grant at edge N, then rvalid[k]=1 and rdata slice k updated for exactly the cycle after N.
REQ-020 rdata slice k SHALL hold its last value until the next granted read for channel k.
REQ-021 Reads and writes SHALL proceed in the same cycle without stalling either.
REQ-022 A single channel with rreq held continuously SHALL receive a grant every cycle (full throughput).
REQ-023 With all NCH channels requesting continuously, each SHALL be granted once every NCH cycles.
REQ-024 Read-during-write to the same address SHALL follow REQ-034/REQ-035.

Reset
REQ-025 On reset=1, rvalid and rdata SHALL go to 0 and the round-robin pointer SHALL be set so that channel 0 has highest priority, without waiting for a clock edge.
REQ-026 Memory contents SHALL NOT be affected by reset.
REQ-027 A read granted in the cycle reset asserts SHALL produce no rvalid.
REQ-028 A write coinciding with a reset edge is undefined; benches SHALL NOT rely on it.
REQ-029 rack SHALL remain a function of rreq and the pointer during reset; requesters SHALL ignore it while reset=1.

Configuration
REQ-030 Macro VRAM_ARB_BYPASS_EN SHALL select read-during-write behaviour.
REQ-031 Without the macro, a same-address same-cycle read SHALL return the old word.
REQ-032 With the macro, a same-address same-cycle read SHALL return the new word: enabled lanes from wdata, other lanes old.
REQ-033 Other behaviour SHALL be identical in both builds.
REQ-034 (alias) The old-data case is REQ-031.
REQ-035 (alias) The new-data case is REQ-032.

Structure
REQ-036 Package vram_pkg SHALL hold the byte-lane count function (DWIDTH/8) and a channel-index width constant (clog2 of NCH, minimum 1).
REQ-037 The round-robin grant logic SHALL be a sub-module rr_arbiter (NCH-wide req in, one-hot grant out, pointer updates on grant).
REQ-038 Memory SHALL be one inferred simple-dual-port array with synchronous read.

Verification
REQ-039 Reset, then write 0xBEEF to 0x10 with wbe=11; ch0 reads 0x10 -> rack[0] same cycle, rvalid[0] next cycle, rdata ch0=0xBEEF.
REQ-040 Memory holds 0xBEEF; write 0x12xx with wbe=10; read -> 0x12EF.
REQ-041 Write 0x5555 and read 0x20 (old 0x1111) in the same cycle -> 0x1111 without VRAM_ARB_BYPASS_EN, 0x5555 with it.
REQ-042 NCH=3, all rreq held 9 cycles -> grant order 0,1,2,0,1,2,0,1,2; each rvalid pulses 3 times.
REQ-043 Assert reset the cycle after a grant -> rvalid stays 0, rdata=0, next grant goes to ch0 with all requesting.
REQ-044 Only ch1 requests 4 consecutive cycles at addresses 1..4 -> 4 consecutive rvalid[1] pulses with the matching data.
